// File: rtl/wb_arb2.sv
// Two-master / one-slave Wishbone classic arbiter with round-robin tie break and bus lock.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arb2 #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [AW-1:0]     m0_adr,
    input  logic [DW-1:0]     m0_dat_o,
    input  logic [DW/8-1:0]   m0_sel,
    output logic [DW-1:0]     m0_dat_i,
    output logic              m0_ack,
    output logic              m0_err,
    output logic              m0_rty,
    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [AW-1:0]     m1_adr,
    input  logic [DW-1:0]     m1_dat_o,
    input  logic [DW/8-1:0]   m1_sel,
    output logic [DW-1:0]     m1_dat_i,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              m1_rty,
    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [AW-1:0]     s_adr,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack,
    input  logic              s_err,
    input  logic              s_rty,
    output logic [1:0]        gnt
);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   err_term;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wb_arb2: TIMEOUT must be at least 2");
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                // last_q == 1 means m1 was served last, so m0 wins a tie
                if (m0_cyc && m1_cyc) begin
                    state_d = last_q ? StGnt0 : StGnt1;
                end else if (m0_cyc) begin
                    state_d = StGnt0;
                end else if (m1_cyc) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (!m0_cyc) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc ? StGnt1 : StIdle;
                end
            end
            StGnt1: begin
                if (!m1_cyc) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc ? StGnt0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign gnt = {state_q == StGnt1, state_q == StGnt0};

    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_o = '0;
        s_sel   = '0;
        unique case (state_q)
            StGnt0: begin
                s_cyc   = m0_cyc;
                s_stb   = m0_stb;
                s_we    = m0_we;
                s_adr   = m0_adr;
                s_dat_o = m0_dat_o;
                s_sel   = m0_sel;
            end
            StGnt1: begin
                s_cyc   = m1_cyc;
                s_stb   = m1_stb;
                s_we    = m1_we;
                s_adr   = m1_adr;
                s_dat_o = m1_dat_o;
                s_sel   = m1_sel;
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            to_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter only reaches TIMEOUT after an unbroken stall on the current grant
    always_comb begin
        cnt_d  = '0;
        to_err = 1'b0;
        if (cnt_q == CntW'(TIMEOUT)) begin
            to_err = 1'b1;
        end else if (s_cyc && s_stb && !(s_ack || s_err || s_rty) && (state_d == state_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign err_term = s_err | to_err;
`else
    assign err_term = s_err;
`endif

    assign m0_dat_i = s_dat_i;
    assign m1_dat_i = s_dat_i;
    assign m0_ack   = s_ack    & gnt[0];
    assign m0_err   = err_term & gnt[0];
    assign m0_rty   = s_rty    & gnt[0];
    assign m1_ack   = s_ack    & gnt[1];
    assign m1_err   = err_term & gnt[1];
    assign m1_rty   = s_rty    & gnt[1];

endmodule

// File: tb/tb_wb_arb2.sv
// Scoreboard bench for wb_arb2: grant changes and master terminations are queued by the
// stimulus and checked by a negedge monitor. Timeout test runs only with WB_ARB_TIMEOUT_EN.
module tb_wb_arb2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    localparam logic [5:0] T0_ACK = 6'b000001;
    localparam logic [5:0] T0_ERR = 6'b000010;
    localparam logic [5:0] T0_RTY = 6'b000100;
    localparam logic [5:0] T1_ACK = 6'b001000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic [DW-1:0] m0_dat_o, m1_dat_o, m0_dat_i, m1_dat_i, s_dat_o, s_dat_i;
    logic [DW/8-1:0] m0_sel, m1_sel, s_sel;
    logic m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
    logic [1:0] gnt;

    wb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_o(m0_dat_o), .m0_sel(m0_sel), .m0_dat_i(m0_dat_i),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_o(m1_dat_o), .m1_sel(m1_sel), .m1_dat_i(m1_dat_i),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_o(s_dat_o), .s_sel(s_sel), .s_dat_i(s_dat_i),
        .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
        .gnt(gnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0]  exp_gnt[$];
    logic [5:0]  exp_tv[$];
    logic [31:0] exp_td[$];
    logic [1:0]  gnt_prev = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_term(input logic [5:0] v, input logic [31:0] d);
        exp_tv.push_back(v);
        exp_td.push_back(d);
    endtask

    // Monitor: every grant change and every termination must match the next queued entry
    always @(negedge clk) begin
        logic [5:0] tv;
        if (gnt !== gnt_prev) begin
            if (exp_gnt.size() == 0) chk("gnt_unexpected", {62'd0, gnt}, {62'd0, gnt_prev});
            else chk("gnt", {62'd0, gnt}, {62'd0, exp_gnt.pop_front()});
            gnt_prev = gnt;
        end
        tv = {m1_rty, m1_err, m1_ack, m0_rty, m0_err, m0_ack};
        if (tv != 6'b0) begin
            if (exp_tv.size() == 0) begin
                chk("term_unexpected", {58'd0, tv}, 64'd0);
            end else begin
                logic [31:0] d;
                d = exp_td.pop_front();
                chk("term", {58'd0, tv}, {58'd0, exp_tv.pop_front()});
                chk("m0_dat_i", {32'd0, m0_dat_i}, {32'd0, d});
                chk("m1_dat_i", {32'd0, m1_dat_i}, {32'd0, d});
            end
        end
    end

    task automatic clear_inputs();
        {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
        m0_adr = '0; m1_adr = '0; m0_dat_o = '0; m1_dat_o = '0;
        m0_sel = '0; m1_sel = '0;
        s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Raise both cyc together, expect winner, then drop both
    task automatic tie(input logic [1:0] win);
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        exp_gnt.push_back(win);
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        exp_gnt.push_back(2'b00);
        tick();
    endtask

    initial begin
        clear_inputs();
        #1 rst = 1'b0;
        // Requests and slave ack during reset must not reach the outputs
        m0_cyc = 1'b1; m1_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1;
        tick();
        tick();
        chk("rst_gnt", {62'd0, gnt}, 64'd0);
        chk("rst_s_cyc", {63'd0, s_cyc}, 64'd0);
        chk("rst_s_stb", {63'd0, s_stb}, 64'd0);
        chk("rst_acks", {62'd0, m1_ack, m0_ack}, 64'd0);
        clear_inputs();
        tick();
        rst = 1'b1;
        tick();

        // m0 single read, slave acks two cycles after strobe
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0040; m0_sel = 4'hF;
        m1_adr = 32'h1111_1111;
        exp_gnt.push_back(2'b01);
        tick();
        chk("t1_gnt", {62'd0, gnt}, 64'd1);
        chk("t1_s_adr", {32'd0, s_adr}, 64'h40);
        chk("t1_s_cyc_stb_we", {61'd0, s_cyc, s_stb, s_we}, 64'b110);
        tick();
        tick();
        s_ack = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        push_term(T0_ACK, 32'hDEAD_BEEF);
        tick();
        s_ack = 1'b0; s_dat_i = '0; m0_cyc = 1'b0; m0_stb = 1'b0;
        exp_gnt.push_back(2'b00);
        tick();
        tick();

        // Ties after reset: m0, then handover without dead cycle, then alternation
        do_reset();
        tick();
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        exp_gnt.push_back(2'b01);
        tick();
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        exp_gnt.push_back(2'b10);
        tick();
        m1_cyc = 1'b0; m1_stb = 1'b0;
        exp_gnt.push_back(2'b00);
        tick();
        tie(2'b01);
        tie(2'b10);
        tie(2'b01);

        // m1 locks the bus for four acked write beats while m0 waits
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'h3;
        exp_gnt.push_back(2'b10);
        tick();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_dat_o = 32'hFFFF_0000;
        for (int i = 0; i < 4; i++) begin
            m1_dat_o = 32'hA5A5_0000 + i;
            s_ack = 1'b1; s_dat_i = 32'h0000_1000 + i;
            push_term(T1_ACK, 32'h0000_1000 + i);
            #1;
            chk("t3_s_dat_o", {32'd0, s_dat_o}, {32'd0, 32'hA5A5_0000 + i});
            chk("t3_s_sel", {60'd0, s_sel}, 64'h3);
            tick();
        end
        s_ack = 1'b0; s_dat_i = '0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        exp_gnt.push_back(2'b01);
        tick();
        chk("t3_s_dat_o_m0", {32'd0, s_dat_o}, 64'hFFFF_0000);

        // m0 still granted, m1 waiting: err then rty go to m0 only
        m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        s_err = 1'b1;
        push_term(T0_ERR, 32'd0);
        tick();
        s_err = 1'b0;
        tick();
        s_rty = 1'b1;
        push_term(T0_RTY, 32'd0);
        tick();
        s_rty = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        exp_gnt.push_back(2'b10);
        tick();

        // Async reset mid-burst while m1 holds the grant and is being acked
        s_ack = 1'b1;
        push_term(T1_ACK, 32'd0);
        @(negedge clk);
        #1;
        exp_gnt.push_back(2'b00);
        rst = 1'b0;
        #1;
        chk("arst_gnt", {62'd0, gnt}, 64'd0);
        chk("arst_s_cyc", {63'd0, s_cyc}, 64'd0);
        chk("arst_m1_ack", {63'd0, m1_ack}, 64'd0);
        clear_inputs();
        tick();
        rst = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        exp_gnt.push_back(2'b01);
        tick();
        chk("arst_tie_gnt", {62'd0, gnt}, 64'd1);
        clear_inputs();
        exp_gnt.push_back(2'b00);
        tick();
        tick();

        // Stalled strobe: watchdog err exactly 8 cycles after the first s_stb, or never
        m0_cyc = 1'b1; m0_stb = 1'b1;
        exp_gnt.push_back(2'b01);
`ifdef WB_ARB_TIMEOUT_EN
        push_term(T0_ERR, 32'd0);
`endif
        tick();
        for (int k = 0; k < 12; k++) begin
`ifdef WB_ARB_TIMEOUT_EN
            chk("to_m0_err", {63'd0, m0_err}, {63'd0, k == TO});
`else
            chk("to_m0_err", {63'd0, m0_err}, 64'd0);
`endif
            tick();
        end
        clear_inputs();
        exp_gnt.push_back(2'b00);
        tick();
        tick();
        tick();

        chk("gnt_queue_empty", 64'(exp_gnt.size()), 64'd0);
        chk("term_queue_empty", 64'(exp_tv.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arb2.md
Name: wb_arb2

Overview:
- Two-master, one-slave Wishbone classic arbiter, round-robin.
- Sits between the CPU instruction/data masters and the shared memory slave, on the same buses the performance monitor snoops.
- Grants the slave to one master per bus cycle, with grant held until that master drops cyc.
- Returns ack/err/rty to the granted master only.

Parameters:
- AW, 32, address width
- DW, 32, data width (sel width = DW/8)
- TIMEOUT, 255, watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN), must be ≥ 2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle/strobe/write
- m0_adr  in  AW  master 0 address
- m0_dat_o  in  DW  master 0 write data
- m0_sel  in  DW/8  master 0 byte selects
- m0_dat_i  out  DW  read data to master 0
- m0_ack, m0_err, m0_rty  out  1 each  terminations to master 0
- m1_*  identical set for master 1
- s_cyc, s_stb, s_we  out  1 each  to slave
- s_adr  out  AW  to slave
- s_dat_o  out  DW  to slave
- s_sel  out  DW/8  to slave
- s_dat_i  in  DW  slave read data
- s_ack, s_err, s_rty  in  1 each  slave terminations
- gnt  out  2  one-hot grant, {m1,m0}, registered

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, gnt=2'b00, last=1 (m0 wins first tie), watchdog count=0.
  - All s_* control outputs 0; all mN_ack/err/rty 0.
- State register: IDLE, GNT0, GNT1. Grant changes only on the clk rising edge.
- IDLE:
  - m0_cyc only -> GNT0; m1_cyc only -> GNT1.
  - Both requesting -> the master not equal to last.
  - Neither requesting -> stay in IDLE.
- GNTx:
  - Hold while mx_cyc=1, even across multiple stb/ack beats (bus lock).
  - When mx_cyc=0: if the other master's cyc=1, go directly to GNTother (no dead cycle); else go to IDLE.
  - last<=x on leaving GNTx.
- Latency: a request in cycle N sees gnt, and s_cyc/s_stb, from cycle N+1. Combinational slave termination returns in the same cycle.
- Muxing is combinational on the registered state:
  - s_adr/s_dat_o/s_sel/s_we/s_cyc/s_stb come from the granted master.
  - In IDLE: s_cyc=s_stb=s_we=0; s_adr/s_dat_o/s_sel are don't-care, driven 0.
- s_dat_i is broadcast to both mN_dat_i.
- mN_ack/err/rty = slave signal AND gnt[N]; the ungranted master never sees a termination.
- A master dropping cyc mid-transfer with no ack is legal: grant is released and the slave sees cyc fall the same cycle.
- Reset asserted mid-transfer: outputs drop immediately (asynchronous); no termination is generated.
- A master holding cyc indefinitely starves the other. This is by design (lock semantics); no forced preemption.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) increments each cycle s_cyc&s_stb=1 with no s_ack/s_err/s_rty.
  - It clears on any termination, on a grant change, or when stb=0.
  - On reaching TIMEOUT the arbiter asserts mN_err to the granted master for exactly one cycle, even with s_err=0, and clears the counter.
  - Grant is unaffected; the master is expected to drop cyc.
- Undefined: no counter logic; err is purely passed through from the slave.

Test Plan:
- Reset, then m0 single read at adr 0x0000_0040, slave acks 2 cycles after s_stb with s_dat_i=0xDEAD_BEEF -> gnt=01 one cycle after m0_cyc; m0_ack=1 with m0_dat_i=0xDEADBEEF; m1_ack stays 0.
- m0_cyc and m1_cyc both rise in the same cycle after reset -> m0 granted first. When m0 drops cyc, m1 is granted on the very next edge (gnt 01->10, never 00). A repeat tie is then won by m0, alternating on each tie.
- m1 holds cyc for 4 write beats, each acked (s_ack on beats 1-4), while m0 requests -> gnt stays 10 for all 4 beats; m0 never sees ack; m0 is granted the cycle after m1_cyc falls.
- m0 granted, s_err=1 one cycle -> m0_err=1, m1_err=0. With s_rty instead -> m0_rty=1 only.
- Assert rst=0 asynchronously mid-burst while GNT1 -> s_cyc, gnt and m1_ack fall without waiting for a clock edge. After release, a simultaneous request from both masters grants m0.
- WB_ARB_TIMEOUT_EN with TIMEOUT=8: m0 strobes and the slave never responds -> m0_err pulses for one cycle, 8 cycles after the first s_stb. Same run without the macro -> no err ever.
